// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and the command-master FSM state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/ahb_cmd_master_if.sv
// rtl/ahb_cmd_master_if.sv - command/response and AHB bus bundle for ahb_cmd_master
interface ahb_cmd_master_if #(
  parameter int ADDR_WIDTH = 16
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [2:0]            cmd_size;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;
  logic [1:0]            htrans;
  logic [2:0]            hsize;
  logic                  hwrite;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [31:0]           hwdata;
  logic                  hready;
  logic [1:0]            hresp;
  logic [31:0]           hrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, rsp_ready,
    input  hready, hresp, hrdata,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output htrans, hsize, hwrite, haddr, hwdata
  );

  modport slave (
    input  htrans, hsize, hwrite, haddr, hwdata,
    output hready, hresp, hrdata
  );

endinterface

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - single-outstanding AHB master driven by a command/response stream
// ALIGN_CHECK_EN: answer misaligned or oversized commands with an error without touching the bus.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_err_o,
  output logic [31:0]           rsp_rdata_o,
  output logic [1:0]            htrans_o,
  output logic [2:0]            hsize_o,
  output logic                  hwrite_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [31:0]           hwdata_o,
  input  logic                  hready_i,
  input  logic [1:0]            hresp_i,
  input  logic [31:0]           hrdata_i
);

  state_e                state_q, state_d;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  cmd_fire;
  logic                  misaligned;

  assign cmd_fire = cmd_valid_i && (state_q == ST_IDLE);

`ifdef ALIGN_CHECK_EN
  assign misaligned = (cmd_size_i > HSIZE_WORD) ||
                      ((cmd_size_i == HSIZE_HALF) && cmd_addr_i[0]) ||
                      ((cmd_size_i == HSIZE_WORD) && (cmd_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (misaligned) begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (hready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        // An ERROR beat with hready low is only the first half of the response.
        if (hready_i) begin
          state_d     = ST_RESP;
          rsp_err_d   = (hresp_i != HRESP_OKAY);
          rsp_rdata_d = write_q ? 32'h0 : hrdata_i;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      // Rejected commands leave the bus-facing address registers untouched.
      if (cmd_fire && !misaligned) begin
        write_q <= cmd_write_i;
        size_q  <= cmd_size_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
      end
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign htrans_o    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize_o     = size_q;
  assign hwrite_o    = write_q;
  assign haddr_o     = addr_q;
  assign hwdata_o    = (state_q == ST_DATA) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb/tb_ahb_cmd_master.sv - self-checking bench for ahb_cmd_master with a byte-memory AHB slave
module tb_ahb_cmd_master;
  import ahb_pkg::*;

  localparam int AW = 16;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_cmd_master_if #(.ADDR_WIDTH(AW)) bus ();

  ahb_cmd_master #(.ADDR_WIDTH(AW)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .cmd_valid_i (bus.cmd_valid),
    .cmd_ready_o (bus.cmd_ready),
    .cmd_write_i (bus.cmd_write),
    .cmd_size_i  (bus.cmd_size),
    .cmd_addr_i  (bus.cmd_addr),
    .cmd_wdata_i (bus.cmd_wdata),
    .rsp_valid_o (bus.rsp_valid),
    .rsp_ready_i (bus.rsp_ready),
    .rsp_err_o   (bus.rsp_err),
    .rsp_rdata_o (bus.rsp_rdata),
    .htrans_o    (bus.htrans),
    .hsize_o     (bus.hsize),
    .hwrite_o    (bus.hwrite),
    .haddr_o     (bus.haddr),
    .hwdata_o    (bus.hwdata),
    .hready_i    (bus.hready),
    .hresp_i     (bus.hresp),
    .hrdata_i    (bus.hrdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cfg_wait = 0;
  bit cfg_err  = 1'b0;

  logic [7:0] smem [256] = '{default: 8'h00};
  logic [7:0] rmem [256] = '{default: 8'h00};

  logic       s_dphase;
  logic       s_write;
  logic [2:0] s_size;
  logic [7:0] s_addr;
  int         s_wait;

  function automatic logic [31:0] slave_word(input logic [7:0] a);
    int b;
    b = int'(a) & 32'hFC;
    return {smem[b+3], smem[b+2], smem[b+1], smem[b]};
  endfunction

  function automatic bit lane_en(input logic [2:0] sz, input logic [7:0] a, input int i);
    if (sz == 3'd0) return (i == int'(a[1:0]));
    if (sz == 3'd1) return ((i / 2) == int'(a[1]));
    return 1'b1;
  endfunction

  always_comb begin
    bus.hready = !(s_dphase && (s_wait > 0));
    bus.hresp  = (s_dphase && cfg_err) ? 2'b01 : 2'b00;
    if (!s_dphase || s_write)
      bus.hrdata = 32'h0;
    else if (s_wait > 0)
      bus.hrdata = 32'hBAD0BAD0;
    else
      bus.hrdata = slave_word(s_addr);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s_dphase <= 1'b0;
      s_wait   <= 0;
      s_write  <= 1'b0;
      s_size   <= 3'd0;
      s_addr   <= 8'h0;
    end else begin
      if (s_dphase) begin
        if (s_wait > 0) begin
          s_wait <= s_wait - 1;
        end else begin
          if (s_write && !cfg_err)
            for (int i = 0; i < 4; i++)
              if (lane_en(s_size, s_addr, i)) smem[{s_addr[7:2], 2'(i)}] <= bus.hwdata[8*i +: 8];
          s_dphase <= 1'b0;
        end
      end
      if (bus.htrans == 2'b10 && bus.hready) begin
        s_dphase <= 1'b1;
        s_write  <= bus.hwrite;
        s_size   <= bus.hsize;
        s_addr   <= bus.haddr[7:0];
        s_wait   <= cfg_err ? ((cfg_wait < 1) ? 1 : cfg_wait) : cfg_wait;
      end
    end
  end

  // Transaction-level reference memory: writes cover the naturally aligned 1/2/4-byte container.
  function automatic logic [31:0] ref_word(input logic [15:0] a);
    int b;
    b = int'(a[7:0]) - (int'(a[7:0]) % 4);
    return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
  endfunction

  task automatic ref_write(input logic [2:0] sz, input logic [15:0] a, input logic [31:0] wd);
    int nb, base;
    nb   = 1 << sz;
    base = int'(a[7:0]) - (int'(a[7:0]) % nb);
    for (int k = 0; k < nb; k++) rmem[base+k] = wd[8*((base+k)%4) +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_cmd(input logic wr, input logic [2:0] sz, input logic [15:0] a,
                         input logic [31:0] wd, input int wt, input bit er, input int rdly,
                         input bit skip, output logic [31:0] rd_o, output logic err_o);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat, lat, nseen;
    cfg_wait = wt;
    cfg_err  = er;
    exp_err  = skip | er;
    exp_lat  = skip ? 1 : 3 + (er ? ((wt < 1) ? 1 : wt) : wt);
    exp_rd   = (wr || skip) ? 32'h0 : ref_word(a);
    if (wr && !exp_err) ref_write(sz, a, wd);

    @(negedge hclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_size  = sz;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge hclk);
    lat   = 0;
    nseen = 0;
    while (1) begin
      @(negedge hclk);
      bus.cmd_valid = 1'b0;
      lat++;
      if (bus.htrans == HTRANS_NONSEQ) begin
        nseen++;
        chk("addr_phase_haddr", 32'(bus.haddr), 32'(a));
        chk("addr_phase_hsize", 32'(bus.hsize), 32'(sz));
        chk("addr_phase_hwrite", 32'(bus.hwrite), 32'(wr));
      end else if (nseen > 0) begin
        chk("haddr_retained", 32'(bus.haddr), 32'(a));
      end
      chk("hwdata", bus.hwdata, s_dphase ? wd : 32'h0);
      if (bus.rsp_valid) break;
      if (lat > 40) begin
        chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("nonseq_count", 32'(nseen), skip ? 32'd0 : 32'd1);
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'd0);
    rd_o  = bus.rsp_rdata;
    err_o = bus.rsp_err;
    for (int i = 0; i < rdly; i++) begin
      @(negedge hclk);
      chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_hold_err", 32'(bus.rsp_err), 32'(exp_err));
      chk("rsp_hold_rdata", bus.rsp_rdata, exp_rd);
    end
    bus.rsp_ready = 1'b1;
    @(negedge hclk);
    bus.rsp_ready = 1'b0;
    chk("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rsp_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, "_htrans"}, 32'(bus.htrans), 32'd0);
    chk({tag, "_hsize"}, 32'(bus.hsize), 32'd0);
    chk({tag, "_hwrite"}, 32'(bus.hwrite), 32'd0);
    chk({tag, "_haddr"}, 32'(bus.haddr), 32'd0);
    chk({tag, "_hwdata"}, bus.hwdata, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er_o;
    logic [2:0]  sz;
    logic [15:0] a;

    hresetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 3'd0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    #12;
    chk_zero_outputs("reset");
    @(negedge hclk);
    hresetn = 1'b1;

    run_cmd(1'b1, HSIZE_WORD, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0, rd, er_o);
    run_cmd(1'b0, HSIZE_WORD, 16'h0010, 32'h0, 0, 1'b0, 0, 1'b0, rd, er_o);
    chk("word_readback", rd, 32'hDEADBEEF);

    run_cmd(1'b1, HSIZE_BYTE, 16'h0013, 32'hAB000000, 0, 1'b0, 0, 1'b0, rd, er_o);
    run_cmd(1'b0, HSIZE_WORD, 16'h0010, 32'h0, 0, 1'b0, 0, 1'b0, rd, er_o);
    chk("byte_merge_readback", rd, 32'hABADBEEF);

    run_cmd(1'b0, HSIZE_WORD, 16'h0010, 32'h5555AAAA, 2, 1'b0, 0, 1'b0, rd, er_o);
    run_cmd(1'b0, HSIZE_WORD, 16'h0010, 32'h0, 0, 1'b1, 0, 1'b0, rd, er_o);
    chk("read_error_flag", 32'(er_o), 32'd1);
    run_cmd(1'b1, HSIZE_HALF, 16'h0012, 32'h12340000, 1, 1'b1, 1, 1'b0, rd, er_o);
    run_cmd(1'b0, HSIZE_WORD, 16'h0010, 32'h0, 0, 1'b0, 3, 1'b0, rd, er_o);
    chk("error_write_dropped", rd, 32'hABADBEEF);

`ifdef ALIGN_CHECK_EN
    run_cmd(1'b0, HSIZE_WORD, 16'h0002, 32'h0, 0, 1'b0, 0, 1'b1, rd, er_o);
    run_cmd(1'b1, HSIZE_HALF, 16'h0021, 32'hFFFFFFFF, 0, 1'b0, 0, 1'b1, rd, er_o);
    run_cmd(1'b0, 3'b011, 16'h0020, 32'h0, 0, 1'b0, 1, 1'b1, rd, er_o);
`else
    run_cmd(1'b0, HSIZE_WORD, 16'h0002, 32'h0, 0, 1'b0, 0, 1'b0, rd, er_o);
`endif

    for (int n = 0; n < 30; n++) begin
      sz = 3'($urandom_range(0, 2));
      a  = 16'($urandom_range(0, 255)) & ~16'((1 << sz) - 1);
      run_cmd(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'b0, rd, er_o);
    end

    cfg_wait = 3;
    cfg_err  = 1'b0;
    @(negedge hclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_size  = HSIZE_WORD;
    bus.cmd_addr  = 16'h0020;
    bus.cmd_wdata = 32'h12345678;
    @(negedge hclk);
    bus.cmd_valid = 1'b0;
    chk("mid_addr_htrans", 32'(bus.htrans), 32'(HTRANS_NONSEQ));
    @(negedge hclk);
    chk("mid_in_data", 32'(s_dphase), 32'd1);
    chk("mid_hwdata", bus.hwdata, 32'h12345678);
    #2 hresetn = 1'b0;
    #1 chk_zero_outputs("async_reset");
    @(negedge hclk);
    hresetn  = 1'b1;
    cfg_wait = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk("post_reset_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    end
    run_cmd(1'b0, HSIZE_WORD, 16'h0020, 32'h0, 0, 1'b0, 0, 1'b0, rd, er_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the byte-address width of haddr_o and cmd_addr_i.
REQ-002 SHALL have ports:
- hclk  in  1  clock; all flops on its rising edge.
- hresetn  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_size_i  in  3  HSIZE encoding.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_wdata_i  in  32  write data, lane-aligned.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_err_o  out  1  1=ERROR response.
- rsp_rdata_o  out  32  read data.
- htrans_o  out  2  AHB transfer type.
- hsize_o  out  3  AHB size.
- hwrite_o  out  1  AHB direction.
- haddr_o  out  ADDR_WIDTH  AHB address.
- hwdata_o  out  32  AHB write data.
- hready_i  in  1  AHB ready.
- hresp_i  in  2  AHB response.
- hrdata_i  in  32  AHB read data.

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one transfer in flight, no pipelining of address phases.
REQ-004 cmd_ready_o SHALL be 1 exactly when state is IDLE; a handshake latches write, size, addr and wdata and moves the FSM to ADDR.
REQ-005 In ADDR, outputs SHALL be: htrans_o=NONSEQ (2'b10), with haddr_o, hsize_o and hwrite_o set from the latched command.
REQ-005a In all other states, htrans_o SHALL be IDLE (2'b00).
REQ-006 ADDR SHALL move to DATA on the first cycle with hready_i=1; while hready_i=0, address-phase outputs SHALL be held stable.
REQ-007 In DATA, hwdata_o SHALL equal the latched wdata.
REQ-007a In DATA, the FSM SHALL wait while hready_i=0.
REQ-007b On DATA with hready_i=1, the FSM SHALL capture rsp_err_o=(hresp_i!=2'b00) and rsp_rdata_o (hrdata_i for reads, 0 for writes), then go to RESP.
REQ-008 An hresp_i=ERROR cycle with hready_i=0 (first error cycle) SHALL NOT end the data phase; capture occurs only on the hready_i=1 cycle.
REQ-009 rsp_valid_o SHALL be 1 exactly in RESP; RESP SHALL move to IDLE on rsp_ready_i=1, and rsp_* SHALL be held stable until then.
REQ-010 Zero-wait-state latency: handshake at cycle 0, address phase at cycle 1, data phase at cycle 2, rsp_valid_o=1 at cycle 3; each hready_i=0 cycle adds one.
REQ-011 hwdata_o SHALL be 0 outside DATA.
REQ-011a haddr_o, hsize_o and hwrite_o SHALL retain their last values outside ADDR.
REQ-012 A new command SHALL NOT be accepted in the cycle rsp_ready_i completes RESP; earliest acceptance is the following cycle.

Reset
REQ-013 Asserting hresetn low SHALL asynchronously force state IDLE and all registered outputs to 0, including mid-transfer; the transfer is abandoned with no response.
REQ-013a cmd_ready_o SHALL be 1 while hresetn is low and after reset, because it follows IDLE.

Configuration
REQ-014 With ALIGN_CHECK_EN defined, certain commands SHALL skip the bus, with htrans_o kept at IDLE, and go from the handshake directly to RESP with rsp_err_o=1 and rsp_rdata_o=0. This applies to:
- cmd_size_i>3'b010;
- halfword with cmd_addr_i[0]=1;
- word with cmd_addr_i[1:0]!=0.
REQ-015 Without ALIGN_CHECK_EN, all commands SHALL be issued on the bus unchanged.

Structure
REQ-016 Shared package ahb_pkg SHALL hold HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD and HRESP_OKAY/ERROR constants plus the FSM state typedef.
REQ-017 The block SHALL be a single module with no sub-module; the alignment check is inline logic.

Verification
REQ-018 Word write addr 0x0010 data 0xDEADBEEF, then word read 0x0010, with hready_i=1 against the memory slave -> read rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid_o at cycle 3.
REQ-019 Byte write 0xAB to 0x0013, then word read 0x0010 -> 0xABADBEEF; hsize_o=0 and haddr_o=0x0013 during the address phase.
REQ-020 Slave holds hready_i=0 for 2 data-phase cycles on a read -> rsp_valid_o at cycle 5, and hwdata_o/haddr_o stable throughout.
REQ-021 Two-cycle ERROR (hresp_i=01 with hready_i=0, then hresp_i=01 with hready_i=1) -> rsp_err_o=1, with no capture on the first cycle.
REQ-022 ALIGN_CHECK_EN defined, word read at 0x0002 -> htrans_o stays 00, rsp_err_o=1 at cycle 1; without the macro the bus issues NONSEQ at 0x0002.
REQ-023 rsp_ready_i=0 for 3 cycles, and hresetn pulsed low during DATA -> response held stable; after reset, outputs are 0, cmd_ready_o=1 and no rsp_valid_o.
